// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate chunk extender: mode codes,
// FSM state encoding and the parameter width check.
package imm_ext_pkg;

    localparam logic [1:0] MODE_SIGN  = 2'b00;
    localparam logic [1:0] MODE_ZERO  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_t;

    // All chunks of a full-length immediate must fit in the output word.
    function automatic bit widths_ok(input int imm_w, input int max_chunks, input int data_w);
        return (imm_w * max_chunks) <= data_w;
    endfunction

endpackage

// File: rtl/imm_ext_format.sv
// Combinational formatter: takes the low count*IMM_W bits of the
// accumulator and sign-extends, zero-extends or left-justifies them.
module imm_ext_format
    import imm_ext_pkg::*;
#(
    parameter int IMM_W      = 6,
    parameter int DATA_W     = 32,
    parameter int MAX_CHUNKS = 4
) (
    input  logic [IMM_W*MAX_CHUNKS-1:0]      acc,
    input  logic [$clog2(MAX_CHUNKS+1)-1:0]  count,
    input  logic [1:0]                       mode,
    output logic [DATA_W-1:0]                data
);

    localparam int SH_W = $clog2(DATA_W + 1);

    logic [SH_W-1:0]   nbits;
    logic [SH_W-1:0]   pad;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] aligned;

    // Left-justify the valid bits, then shift back down (logical or
    // arithmetic) so any stale bits above N fall off the top.
    always_comb begin
        nbits   = SH_W'(count) * SH_W'(IMM_W);
        pad     = SH_W'(DATA_W) - nbits;
        word    = DATA_W'(acc);
        aligned = word << pad;
        case (mode)
            MODE_ZERO:  data = aligned >> pad;
            MODE_UPPER: data = aligned;
            default:    data = $unsigned($signed(aligned) >>> pad);
        endcase
    end

endmodule

// File: rtl/imm_chunk_extender.sv
// Multi-cycle immediate builder: collects IMM_W-bit chunks MSB-first over
// a valid/ready stream and emits one extended DATA_W-bit operand.
module imm_chunk_extender
    import imm_ext_pkg::*;
#(
    parameter int IMM_W      = 6,
    parameter int DATA_W     = 32,
    parameter int MAX_CHUNKS = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [IMM_W-1:0]                  in_imm,
    input  logic                              in_last,
    input  logic [1:0]                        in_mode,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_W-1:0]                 out_data,
    output logic [$clog2(MAX_CHUNKS+1)-1:0]   out_chunks,
    output logic                              overflow_err
);

    localparam int ACC_W = IMM_W * MAX_CHUNKS;
    localparam int CNT_W = $clog2(MAX_CHUNKS + 1);

    if (!widths_ok(IMM_W, MAX_CHUNKS, DATA_W)) begin : g_bad_widths
        $error("imm_chunk_extender: IMM_W*MAX_CHUNKS exceeds DATA_W");
    end

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nxt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [1:0]        mode;
    logic [1:0]        mode_nxt;
    logic              accept;
    logic              hit_max;
    logic              to_hold;
    logic              overflow;
    logic [DATA_W-1:0] fmt_data;

    assign in_ready = !reset && (state != HOLD);
    assign accept   = in_valid && in_ready;

    // Post-accept view of acc/count/mode so the result can be formatted and
    // registered on the same edge that takes the final chunk.
    always_comb begin
        acc_nxt   = acc;
        count_nxt = count;
        mode_nxt  = mode;
        hit_max   = 1'b0;
        to_hold   = 1'b0;
        overflow  = 1'b0;
        if (accept) begin
            if (state == IDLE) begin
                acc_nxt   = ACC_W'(in_imm);
                count_nxt = CNT_W'(1);
                mode_nxt  = in_mode;
                to_hold   = in_last;
            end else begin
                acc_nxt   = (acc << IMM_W) | ACC_W'(in_imm);
                count_nxt = count + CNT_W'(1);
                hit_max   = (count_nxt == CNT_W'(MAX_CHUNKS));
                to_hold   = in_last || hit_max;
                overflow  = hit_max && !in_last;
            end
        end
    end

    imm_ext_format #(
        .IMM_W      (IMM_W),
        .DATA_W     (DATA_W),
        .MAX_CHUNKS (MAX_CHUNKS)
    ) u_format (
        .acc   (acc_nxt),
        .count (count_nxt),
        .mode  (mode_nxt),
        .data  (fmt_data)
    );

    // FSM with accumulator, chunk counter and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            mode         <= MODE_SIGN;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_chunks   <= '0;
            overflow_err <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc   <= acc_nxt;
                        count <= count_nxt;
                        mode  <= mode_nxt;
                        if (to_hold) begin
                            state        <= HOLD;
                            out_valid    <= 1'b1;
                            out_data     <= fmt_data;
                            out_chunks   <= count_nxt;
                            overflow_err <= overflow;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state        <= IDLE;
                        out_valid    <= 1'b0;
                        overflow_err <= 1'b0;
                        count        <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_chunk_extender.sv
// Directed self-checking bench for imm_chunk_extender (defaults 6/32/4).
module tb_imm_chunk_extender;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_imm;
    logic        in_last;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_chunks;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;

    imm_chunk_extender #(
        .IMM_W      (6),
        .DATA_W     (32),
        .MAX_CHUNKS (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_imm       (in_imm),
        .in_last      (in_last),
        .in_mode      (in_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_chunks   (out_chunks),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [5:0] imm, input logic last, input logic [1:0] mode);
        in_valid = 1'b1;
        in_imm   = imm;
        in_last  = last;
        in_mode  = mode;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_last   = 1'b0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid",    32'(out_valid), 32'd0);
        chk("rst_data",     out_data, 32'd0);
        chk("rst_chunks",   32'(out_chunks), 32'd0);
        chk("rst_ovf",      32'(overflow_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Single chunk, each mode
        send(6'b100011, 1'b1, 2'b00);
        chk("t1_valid",  32'(out_valid), 32'd1);
        chk("t1_data",   out_data, 32'hFFFF_FFE3);
        chk("t1_chunks", 32'(out_chunks), 32'd1);
        chk("t1_hold_ready", 32'(in_ready), 32'd0);
        take("t1");

        send(6'b100011, 1'b1, 2'b01);
        chk("t2_zero", out_data, 32'h0000_0023);
        take("t2z");
        send(6'b100011, 1'b1, 2'b10);
        chk("t2_upper", out_data, 32'h8C00_0000);
        take("t2u");
        send(6'b000011, 1'b1, 2'b10);
        chk("t2_upper_pos", out_data, 32'h0C00_0000);
        take("t2p");
        send(6'b100011, 1'b1, 2'b11);
        chk("t2_rsvd_sign", out_data, 32'hFFFF_FFE3);
        take("t2r");

        // Two chunks, back to back and with an idle gap
        send(6'b111111, 1'b0, 2'b00);
        chk("t3_mid_valid", 32'(out_valid), 32'd0);
        chk("t3_mid_ready", 32'(in_ready), 32'd1);
        send(6'b000011, 1'b1, 2'b01);
        chk("t3_data",   out_data, 32'hFFFF_FFC3);
        chk("t3_chunks", 32'(out_chunks), 32'd2);
        take("t3");

        send(6'b111111, 1'b0, 2'b00);
        in_mode = 2'b01;
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        chk("t3g_gap_valid", 32'(out_valid), 32'd0);
        send(6'b000011, 1'b1, 2'b10);
        chk("t3g_data",   out_data, 32'hFFFF_FFC3);
        chk("t3g_chunks", 32'(out_chunks), 32'd2);
        take("t3g");

        // Overflow: four chunks without in_last
        send(6'h01, 1'b0, 2'b01);
        send(6'h02, 1'b0, 2'b00);
        send(6'h03, 1'b0, 2'b00);
        chk("t4_pre_valid", 32'(out_valid), 32'd0);
        chk("t4_pre_ovf",   32'(overflow_err), 32'd0);
        send(6'h04, 1'b0, 2'b00);
        chk("t4_valid",  32'(out_valid), 32'd1);
        chk("t4_data",   out_data, 32'h0004_20C4);
        chk("t4_ovf",    32'(overflow_err), 32'd1);
        chk("t4_chunks", 32'(out_chunks), 32'd4);
        take("t4");
        chk("t4_ovf_clr", 32'(overflow_err), 32'd0);

        // Backpressure in HOLD with a chunk offered
        send(6'b100011, 1'b1, 2'b00);
        in_valid = 1'b1;
        in_imm   = 6'h15;
        in_last  = 1'b1;
        in_mode  = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_bp_valid", 32'(out_valid), 32'd1);
            chk("t5_bp_data",  out_data, 32'hFFFF_FFE3);
            chk("t5_bp_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        take("t5");
        chk("t5_data_kept", out_data, 32'hFFFF_FFE3);
        send(6'b000001, 1'b1, 2'b01);
        chk("t5_next_data",   out_data, 32'h0000_0001);
        chk("t5_next_chunks", 32'(out_chunks), 32'd1);
        take("t5n");

        // Mid-operation reset
        send(6'h01, 1'b0, 2'b01);
        send(6'h02, 1'b0, 2'b01);
        reset = 1'b1;
        #1;
        chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t6_rst_valid",  32'(out_valid), 32'd0);
        chk("t6_rst_data",   out_data, 32'd0);
        chk("t6_rst_chunks", 32'(out_chunks), 32'd0);
        chk("t6_rst_ovf",    32'(overflow_err), 32'd0);
        chk("t6_rst_ready2", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        send(6'h05, 1'b1, 2'b01);
        chk("t6_fresh_valid",  32'(out_valid), 32'd1);
        chk("t6_fresh_data",   out_data, 32'h0000_0005);
        chk("t6_fresh_chunks", 32'(out_chunks), 32'd1);
        chk("t6_fresh_ovf",    32'(overflow_err), 32'd0);
        take("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
